// File: rtl/gray_sobel_pkg.sv
// Shared definitions for the gray/Sobel datapath: byte phase encoding,
// datapath widths and the default luminance weights.
package gray_sobel_pkg;

   typedef enum logic [1:0] {
      PH_R = 2'd0,
      PH_G = 2'd1,
      PH_B = 2'd2
   } phase_t;

   localparam int PIX_W = 8;
   localparam int ACC_W = 16;
   localparam int ROUND = 128;

   localparam int unsigned DEF_COEF_R = 77;
   localparam int unsigned DEF_COEF_G = 150;
   localparam int unsigned DEF_COEF_B = 29;

endpackage

// File: rtl/rgb_to_gray.sv
// RGB888 byte stream to 8-bit luminance, one grey pixel per accepted R,G,B
// triple, with a one-entry output register on a valid/ready handshake.
module rgb_to_gray
   import gray_sobel_pkg::*;
#(
   parameter int unsigned COEF_R = DEF_COEF_R,
   parameter int unsigned COEF_G = DEF_COEF_G,
   parameter int unsigned COEF_B = DEF_COEF_B
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIX_W-1:0] byte_data,
   input  logic             byte_valid,
   output logic             byte_ready,
   input  logic             sync,
   output logic [PIX_W-1:0] gray_data,
   output logic             gray_valid,
   input  logic             gray_ready,
   output logic             drop
);

   if (COEF_R + COEF_G + COEF_B != 256) begin : g_bad_coef
      $error("rgb_to_gray: COEF_R + COEF_G + COEF_B must equal 256");
   end

   localparam logic [ACC_W-1:0] CR  = ACC_W'(COEF_R);
   localparam logic [ACC_W-1:0] CG  = ACC_W'(COEF_G);
   localparam logic [ACC_W-1:0] CB  = ACC_W'(COEF_B);
   localparam logic [ACC_W-1:0] RND = ACC_W'(ROUND);

   // Weights sum to 256, so the worst-case sum (65408) fits ACC_W unsaturated.
   function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [ACC_W-1:0] c);
      return a + ACC_W'(b) * c;
   endfunction

   function automatic logic [PIX_W-1:0] to_pixel(input logic [ACC_W-1:0] sum);
      return PIX_W'(sum >> (ACC_W - PIX_W));
   endfunction

   phase_t            phase_p0, phase_nxt, cur_ph;
   logic [ACC_W-1:0]  acc_p0, acc_nxt, sum_nxt;
   logic              accept, load;

   assign byte_ready = !(phase_p0 == PH_B && gray_valid && !gray_ready);
   assign accept     = byte_valid && byte_ready;

   always_comb begin
      phase_nxt = phase_p0;
      acc_nxt   = acc_p0;
      sum_nxt   = '0;
      load      = 1'b0;
      // sync restarts the pixel: the byte in this cycle, if any, is red
      cur_ph    = sync ? PH_R : phase_p0;
      if (accept) begin
         unique case (cur_ph)
            PH_R: begin
               acc_nxt   = mac(RND, byte_data, CR);
               phase_nxt = PH_G;
            end
            PH_G: begin
               acc_nxt   = mac(acc_p0, byte_data, CG);
               phase_nxt = PH_B;
            end
            PH_B: begin
               sum_nxt   = mac(acc_p0, byte_data, CB);
               load      = 1'b1;
               acc_nxt   = '0;
               phase_nxt = PH_R;
            end
            default: begin
               acc_nxt   = '0;
               phase_nxt = PH_R;
            end
         endcase
      end else if (sync) begin
         acc_nxt   = '0;
         phase_nxt = PH_R;
      end
   end

   // p0: phase / accumulator state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_p0 <= PH_R;
         acc_p0   <= '0;
         drop     <= 1'b0;
      end else begin
         phase_p0 <= phase_nxt;
         acc_p0   <= acc_nxt;
         drop     <= sync && (phase_p0 != PH_R);
      end
   end

   // p1: output register, loads and drains in the same cycle if both occur
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_data  <= '0;
         gray_valid <= 1'b0;
      end else if (load) begin
         gray_data  <= to_pixel(sum_nxt);
         gray_valid <= 1'b1;
      end else if (gray_ready) begin
         gray_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rgb_to_gray.sv
// Bench for rgb_to_gray: directed scenarios plus a randomized stream, all
// compared against a pixel-level reference model of the converter.
module tb_rgb_to_gray;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;
   logic       sync;
   logic [7:0] gray_data;
   logic       gray_valid;
   logic       gray_ready;
   logic       drop;

   int checks   = 0;
   int failures = 0;

   // reference model: collected bytes of the current pixel and output slot
   int       m_nb;
   int       m_r, m_g;
   bit       m_ov;
   bit [7:0] m_od;
   bit       m_drop;
   bit       stalled_prev;
   bit [7:0] held_data;

   rgb_to_gray dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .sync       (sync),
      .gray_data  (gray_data),
      .gray_valid (gray_valid),
      .gray_ready (gray_ready),
      .drop       (drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit [7:0] luma(input int r, input int g, input int b);
      return 8'((r * 77 + g * 150 + b * 29 + 128) / 256);
   endfunction

   task automatic model_reset();
      m_nb = 0; m_r = 0; m_g = 0;
      m_ov = 1'b0; m_od = 8'h00; m_drop = 1'b0;
      stalled_prev = 1'b0;
   endtask

   // one clock: drive at negedge, check against the model, advance the model
   task automatic cycle(input bit bv, input bit [7:0] bd, input bit sy,
                        input bit gr, output bit rdy);
      bit mr, acc;
      @(negedge clk);
      byte_valid = bv; byte_data = bd; sync = sy; gray_ready = gr;
      #1;
      mr  = !(m_nb == 2 && m_ov && !gr);
      rdy = byte_ready;
      chk("byte_ready", 32'(byte_ready), 32'(mr));
      chk("gray_valid", 32'(gray_valid), 32'(m_ov));
      chk("gray_data",  32'(gray_data),  32'(m_od));
      chk("drop",       32'(drop),       32'(m_drop));
      if (stalled_prev && gray_valid)
         chk("stall_stable", 32'(gray_data), 32'(held_data));
      stalled_prev = gray_valid && !gr;
      held_data    = gray_data;
      acc    = bv && mr;
      m_drop = sy && (m_nb != 0);
      if (m_ov && gr) m_ov = 1'b0;
      if (sy) m_nb = 0;
      if (acc) begin
         case (m_nb)
            0: begin m_r = bd; m_nb = 1; end
            1: begin m_g = bd; m_nb = 2; end
            default: begin
               m_od = luma(m_r, m_g, bd);
               m_ov = 1'b1;
               m_nb = 0;
            end
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pixel(input bit [7:0] r, input bit [7:0] g, input bit [7:0] b,
                        input bit gr);
      bit rdy;
      cycle(1'b1, r, 1'b0, gr, rdy);
      cycle(1'b1, g, 1'b0, gr, rdy);
      cycle(1'b1, b, 1'b0, gr, rdy);
   endtask

   initial begin
      bit rdy;
      bit [7:0] exp_sweep [5];
      bit [7:0] sweep_px [5][3];
      exp_sweep = '{8'd255, 8'd77, 8'd149, 8'd29, 8'd141};
      sweep_px  = '{'{8'd255, 8'd255, 8'd255}, '{8'd255, 8'd0, 8'd0},
                    '{8'd0, 8'd255, 8'd0}, '{8'd0, 8'd0, 8'd255},
                    '{8'd100, 8'd150, 8'd200}};

      rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; sync = 1'b0; gray_ready = 1'b1;
      model_reset();
      #2;
      chk("rst_gray_valid", 32'(gray_valid), 32'd0);
      chk("rst_gray_data",  32'(gray_data),  32'd0);
      chk("rst_byte_ready", 32'(byte_ready), 32'd1);
      chk("rst_drop",       32'(drop),       32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // colour sweep at full rate
      for (int i = 0; i < 5; i++) begin
         pixel(sweep_px[i][0], sweep_px[i][1], sweep_px[i][2], 1'b1);
         chk("sweep_valid", 32'(gray_valid), 32'd1);
         chk("sweep_data",  32'(gray_data),  32'(exp_sweep[i]));
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1, rdy);

      // backpressure
      pixel(8'd10, 8'd10, 8'd10, 1'b0);
      chk("bp_first", 32'(gray_data), 32'd10);
      cycle(1'b1, 8'd20, 1'b0, 1'b0, rdy);
      chk("bp_ready_r", 32'(rdy), 32'd1);
      cycle(1'b1, 8'd20, 1'b0, 1'b0, rdy);
      chk("bp_ready_g", 32'(rdy), 32'd1);
      cycle(1'b1, 8'd20, 1'b0, 1'b0, rdy);
      chk("bp_ready_b", 32'(rdy), 32'd0);
      chk("bp_hold", 32'(gray_data), 32'd10);
      cycle(1'b1, 8'd20, 1'b0, 1'b1, rdy);
      chk("bp_ready_release", 32'(rdy), 32'd1);
      chk("bp_second", 32'(gray_data), 32'd20);
      chk("bp_second_valid", 32'(gray_valid), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, rdy);
      chk("bp_drained", 32'(gray_valid), 32'd0);

      // sync mid-pixel
      cycle(1'b1, 8'd50, 1'b0, 1'b1, rdy);
      cycle(1'b1, 8'd60, 1'b0, 1'b1, rdy);
      cycle(1'b1, 8'd0, 1'b1, 1'b1, rdy);
      chk("sync_drop", 32'(drop), 32'd1);
      cycle(1'b1, 8'd0, 1'b0, 1'b1, rdy);
      chk("sync_drop_once", 32'(drop), 32'd0);
      cycle(1'b1, 8'd0, 1'b0, 1'b1, rdy);
      chk("sync_data", 32'(gray_data), 32'd0);
      chk("sync_valid", 32'(gray_valid), 32'd1);

      // idle sync while in the G phase
      cycle(1'b1, 8'd5, 1'b0, 1'b1, rdy);
      cycle(1'b0, 8'd0, 1'b1, 1'b1, rdy);
      chk("idle_sync_drop", 32'(drop), 32'd1);
      pixel(8'd255, 8'd255, 8'd255, 1'b1);
      chk("idle_sync_data", 32'(gray_data), 32'd255);

      // sync in R phase is harmless
      cycle(1'b0, 8'd0, 1'b1, 1'b1, rdy);
      chk("sync_r_nodrop", 32'(drop), 32'd0);

      // reset with an output pending and a partial pixel
      pixel(8'd30, 8'd30, 8'd30, 1'b0);
      cycle(1'b1, 8'd99, 1'b0, 1'b0, rdy);
      chk("pre_rst_pending", 32'(gray_valid), 32'd1);
      @(negedge clk);
      byte_valid = 1'b0; rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(gray_valid), 32'd0);
      chk("mid_rst_data",  32'(gray_data),  32'd0);
      chk("mid_rst_ready", 32'(byte_ready), 32'd1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      pixel(8'd0, 8'd255, 8'd0, 1'b1);
      chk("post_rst_data", 32'(gray_data), 32'd149);

      // random stream
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0), rdy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
